// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshakes on both sides.
// A running accumulator lets each operation take the previous legal result as operand B.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic             err
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOTA = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;

  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  function automatic logic [WIDTH-1:0] bitwise_op(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] z,
                                                  input logic [2:0]       sel);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = x & z;
      OP_OR:   r = x | z;
      OP_NOTA: r = ~x;
      OP_NOR:  r = ~(x | z);
      OP_NAND: r = ~(x & z);
      OP_XOR:  r = x ^ z;
      OP_XNOR: r = ~(x ^ z);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s1_chain_q, s1_chain_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s1_advance_s;
  logic             accept_s;
  logic             illegal_s;
  logic [WIDTH-1:0] opb_s;
  logic [WIDTH-1:0] res_s;

  // Handshake decode and next-state for both stages and the accumulator.
  always_comb begin
    s1_advance_s = s1_valid_q && (!out_valid_q || out_ready);
    in_ready     = !s1_valid_q || s1_advance_s;
    accept_s     = in_valid && in_ready;
    illegal_s    = (s1_op_q == 3'b111);
    opb_s        = s1_chain_q ? acc_q : s1_b_q;
    res_s        = bitwise_op(s1_a_q, opb_s, s1_op_q);

    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s1_chain_d  = s1_chain_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    err_d       = err_q;
    acc_d       = acc_q;

    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_op_d    = op;
      s1_chain_d = chain;
    end else if (s1_advance_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // Illegal ops report a zero result with err set and leave acc untouched.
    if (s1_advance_s) begin
      out_valid_d = 1'b1;
      if (illegal_s) begin
        y_d      = {WIDTH{1'b0}};
        zero_d   = 1'b1;
        parity_d = 1'b0;
        err_d    = 1'b1;
      end else begin
        y_d      = res_s;
        zero_d   = (res_s == {WIDTH{1'b0}});
        parity_d = parity_of(res_s);
        err_d    = 1'b0;
        acc_d    = res_s;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline, result and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= {WIDTH{1'b0}};
      s1_b_q      <= {WIDTH{1'b0}};
      s1_op_q     <= 3'b000;
      s1_chain_q  <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= {WIDTH{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_chain_q  <= s1_chain_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign err       = err_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: offers are queued, accepted ops are modelled
// into a scoreboard, and every consumed result is compared in order.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       chain;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       parity;
  logic       err;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       chain;
  } offer_t;

  offer_t      offer_q[$];
  logic [10:0] sb_q[$];
  logic [7:0]  m_acc;
  logic [7:0]  last_y;
  logic [7:0]  y_hold;
  int          consumed;
  int          errors;
  int          checks;
  bit          rnd_ready;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .chain(chain), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero), .parity(parity), .err(err)
  );

  // Reference result packed as {y, zero, parity, err}; updates the model accumulator.
  function automatic logic [10:0] model(input offer_t o);
    logic [7:0] bb;
    logic [7:0] r;
    bb = o.chain ? m_acc : o.b;
    case (o.op)
      3'd0: r = o.a & bb;
      3'd1: r = o.a | bb;
      3'd2: r = ~o.a;
      3'd3: r = ~(o.a | bb);
      3'd4: r = ~(o.a & bb);
      3'd5: r = o.a ^ bb;
      3'd6: r = ~(o.a ^ bb);
      default: r = 8'h00;
    endcase
    if (o.op == 3'd7) return {8'h00, 1'b1, 1'b0, 1'b1};
    m_acc = r;
    return {r, (r == 8'h00), ^r, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (offer_q.size() != 0) begin
      in_valid = 1'b1;
      a        = offer_q[0].a;
      b        = offer_q[0].b;
      op       = offer_q[0].op;
      chain    = offer_q[0].chain;
    end else begin
      in_valid = 1'b0;
      a        = $urandom_range(0, 255);
      b        = $urandom_range(0, 255);
      op       = $urandom_range(0, 7);
      chain    = $urandom_range(0, 1);
    end
  endtask

  task automatic offer(input logic [7:0] oa, input logic [7:0] ob,
                       input logic [2:0] oop, input logic och);
    offer_t o;
    o.a = oa; o.b = ob; o.op = oop; o.chain = och;
    offer_q.push_back(o);
    drive();
  endtask

  // One clock: observe handshakes at the falling edge, then re-drive after the rising edge.
  task automatic tick();
    logic [10:0] e;
    @(negedge clk);
    if (in_valid && in_ready && rst_n) begin
      sb_q.push_back(model(offer_q[0]));
      void'(offer_q.pop_front());
    end
    if (out_valid && out_ready && rst_n) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious: observed=result y=%h expected=no result", y);
      end else begin
        e = sb_q.pop_front();
        check("result", {21'd0, y, zero, parity, err}, {21'd0, e});
        last_y = y;
        consumed++;
      end
    end
    @(posedge clk);
    #1;
    drive();
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || offer_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check("drain_timeout", n < 300, 1);
  endtask

  initial begin
    errors = 0; checks = 0; consumed = 0; rnd_ready = 1'b0;
    m_acc = 8'h00; last_y = 8'h00;
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 3'd0; chain = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {out_valid, y, zero, parity, err}, 12'h000);
    rst_n = 1'b1;
    check("rst_in_ready_after", in_ready, 1);

    // Latency: accept at edge N, visible after N+1.
    offer(8'hF0, 8'hCC, 3'd0, 1'b0);
    tick();
    check("lat_edge_n", out_valid, 0);
    tick();
    check("lat_edge_n1", out_valid, 1);
    drain();

    // Truth sweep, back to back.
    for (int k = 0; k < 7; k++) offer(8'hF0, 8'hCC, 3'(k), 1'b0);
    repeat (7) tick();
    check("sweep_no_bubble", offer_q.size(), 0);
    repeat (2) tick();
    check("sweep_drained", sb_q.size(), 0);
    check("sweep_last_y", last_y, 8'hC3);

    // Flags.
    offer(8'hAA, 8'h55, 3'd0, 1'b0);
    offer(8'hAA, 8'h55, 3'd1, 1'b0);
    offer(8'h01, 8'h00, 3'd1, 1'b0);
    drain();
    check("flag_last_y", last_y, 8'h01);

    // Chain with out_ready high, then with random out_ready.
    for (int pass = 0; pass < 2; pass++) begin
      rnd_ready = (pass == 1);
      offer(8'h0F, 8'h00, 3'd5, 1'b0);
      offer(8'hFF, 8'hAA, 3'd5, 1'b1);
      drain();
      check("chain_xor", last_y, 8'hF0);
      offer(8'h3C, 8'h00, 3'd0, 1'b1);
      drain();
      check("chain_and", last_y, 8'h30);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    // Backpressure: 3 ops offered, 5 stalled cycles.
    out_ready = 1'b0;
    offer(8'h11, 8'h22, 3'd1, 1'b0);
    offer(8'h33, 8'h0F, 3'd0, 1'b0);
    offer(8'h44, 8'hFF, 3'd5, 1'b0);
    repeat (2) tick();
    y_hold = y;
    repeat (3) tick();
    check("bp_accepted", offer_q.size(), 1);
    check("bp_in_ready", in_ready, 0);
    check("bp_y_held", {out_valid, y}, {1'b1, y_hold});
    consumed = 0;
    out_ready = 1'b1;
    drain();
    check("bp_delivered", consumed, 3);

    // Illegal op leaves the accumulator at its previous value (0x33&0x0F... then 0x44^0xFF).
    offer(8'h12, 8'h34, 3'd7, 1'b0);
    drain();
    check("illegal_flags", {y, zero, parity, err}, {8'h00, 3'b101});
    offer(8'h00, 8'h99, 3'd1, 1'b1);
    drain();
    check("illegal_acc", last_y, 8'hBB);

    // Reset with both stages full.
    out_ready = 1'b0;
    offer(8'h5A, 8'h00, 3'd1, 1'b0);
    offer(8'hA5, 8'h00, 3'd1, 1'b0);
    offer(8'hFF, 8'h00, 3'd1, 1'b0);
    repeat (3) tick();
    check("pre_rst_full", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", {out_valid, y, in_ready}, {1'b0, 8'h00, 1'b1});
    offer_q.delete();
    sb_q.delete();
    m_acc = 8'h00;
    drive();
    out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    check("post_rst_idle", {out_valid, in_ready}, 2'b01);
    offer(8'h00, 8'h77, 3'd1, 1'b1);
    drain();
    check("post_rst_chain", {last_y, zero}, {8'h00, 1'b1});
    repeat (3) tick();
    check("post_rst_quiet", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
